// File: rtl/mano_seq_decode_if.sv
// Control-unit front-end signal bundle: run/sequence controls and bus in,
// timing/decode/IR/indirect results out.
interface mano_seq_decode_if #(
  parameter int NUM_T = 8,
  parameter int WORD  = 16
) ();
  logic             start;
  logic             hlt;
  logic             sc_clr;
  logic [WORD-1:0]  bus_in;
  logic [WORD-1:0]  ir_out;
  logic [NUM_T-1:0] T;
  logic [7:0]       D;
  logic             J;
  logic             run;

  modport master (
    output start, hlt, sc_clr, bus_in,
    input  ir_out, T, D, J, run
  );

  modport slave (
    input  start, hlt, sc_clr, bus_in,
    output ir_out, T, D, J, run
  );
endinterface

// File: rtl/mano_seq_decode.sv
// Basic-computer timing and decode front end: sequence counter, run flip-flop S,
// instruction register IR and indirect flip-flop I feeding the T/D/J control terms.
//
//   state   | meaning
//   --------+---------------------------------------------
//   ST_IDLE | S=0: T forced to zero, SC/IR/I hold
//   ST_RUN  | S=1: SC advances, IR loads at T1, I at T2
module mano_seq_decode #(
  parameter int NUM_T = 8,
  parameter int WORD  = 16
) (
  input logic               clk,
  input logic               rst_n,
  mano_seq_decode_if.slave  bus
);
  localparam int SCW = (NUM_T > 1) ? $clog2(NUM_T) : 1;
  localparam logic [SCW-1:0] SC_MAX = SCW'(NUM_T - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state;
  logic [SCW-1:0]  sc;
  logic [WORD-1:0] ir;
  logic            ind;
  logic [NUM_T-1:0] t;
  logic [7:0]       d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sc    <= '0;
      ir    <= '0;
      ind   <= 1'b0;
    end else begin
      // hlt dominates start when both arrive together
      case (state)
        ST_IDLE: if (bus.start && !bus.hlt) state <= ST_RUN;
        ST_RUN:  if (bus.hlt)               state <= ST_IDLE;
        default:                            state <= ST_IDLE;
      endcase

      if (bus.sc_clr)
        sc <= '0;
      else if (state == ST_RUN)
        sc <= (sc == SC_MAX) ? '0 : sc + 1'b1;

      if (state == ST_RUN && t[1])
        ir <= bus.bus_in;
      if (state == ST_RUN && t[2])
        ind <= ir[WORD-1];
    end
  end

  always_comb begin
    t = '0;
    if (state == ST_RUN)
      t[sc] = 1'b1;
  end

  always_comb begin
    d = '0;
    d[ir[WORD-2:WORD-4]] = 1'b1;
  end

  assign bus.T      = t;
  assign bus.D      = d;
  assign bus.ir_out = ir;
  assign bus.J      = ind;
  assign bus.run    = (state == ST_RUN);
endmodule
